// File: rtl/u409_local_cycle_ctrl_if.sv
// CPU/decoder-side bus signals of the U409 local slow-device cycle controller.
// Bundles the decoder space flags, the CPU handshake and the device strobes/selects.
interface u409_local_cycle_ctrl_if;
   logic TSn;
   logic RnW;
   logic ROM_SPACE;
   logic FLASH_SPACE;
   logic RTC_SPACE;
   logic ATA_SPACE;
   logic AUTOVECTOR;
   logic TAn;
   logic AVECn;
   logic ROMCEn;
   logic FLASHCEn;
   logic RTCCSn;
   logic ATACSn;
   logic OEn;
   logic WEn;
   logic BUSY;

   modport master (
      output TSn, RnW, ROM_SPACE, FLASH_SPACE, RTC_SPACE, ATA_SPACE, AUTOVECTOR,
      input  TAn, AVECn, ROMCEn, FLASHCEn, RTCCSn, ATACSn, OEn, WEn, BUSY
   );

   modport slave (
      input  TSn, RnW, ROM_SPACE, FLASH_SPACE, RTC_SPACE, ATA_SPACE, AUTOVECTOR,
      output TAn, AVECn, ROMCEn, FLASHCEn, RTCCSn, ATACSn, OEn, WEn, BUSY
   );
endinterface

// File: rtl/u409_local_cycle_ctrl.sv
// Sequences 68040 bus cycles to the U409 local slow devices (ROM, flash, RTC, ATA)
// and the autovector acknowledge; all outputs registered from the next-state decode.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for TSn with a decoder flag; all outputs negated
// S_SETUP  | one cycle of CE/CS before the strobe
// S_STROBE | OEn/WEn active; wait-state counter runs down to 1
// S_TERM   | one cycle of TAn (plus AVECn for autovector)
module u409_local_cycle_ctrl #(
   parameter int unsigned ROM_WS   = 4,
   parameter int unsigned FLASH_WS = 3,
   parameter int unsigned RTC_WS   = 8,
   parameter int unsigned ATA_WS   = 6
) (
   input  logic                   CLK40,
   input  logic                   RESETn,
   u409_local_cycle_ctrl_if.slave bus
);

   localparam logic [3:0] ROM_WS_E   = 4'((ROM_WS   == 0) ? 1 : ROM_WS);
   localparam logic [3:0] FLASH_WS_E = 4'((FLASH_WS == 0) ? 1 : FLASH_WS);
   localparam logic [3:0] RTC_WS_E   = 4'((RTC_WS   == 0) ? 1 : RTC_WS);
   localparam logic [3:0] ATA_WS_E   = 4'((ATA_WS   == 0) ? 1 : ATA_WS);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_TERM} state_t;
   typedef enum logic [2:0] {T_ROM, T_FLASH, T_RTC, T_ATA, T_AVEC} tgt_t;

   state_t     state_q, state_d;
   tgt_t       tgt_q, tgt_d;
   logic       rnw_q, rnw_d;
   logic [3:0] cnt_q, cnt_d;

   logic tan_q, tan_d, avecn_q, avecn_d;
   logic romcen_q, romcen_d, flashcen_q, flashcen_d;
   logic rtccsn_q, rtccsn_d, atacsn_q, atacsn_d;
   logic oen_q, oen_d, wen_q, wen_d, busy_q, busy_d;

   logic any_flag;
   logic ce_on, strobe_on, term_on;

   assign any_flag = bus.AUTOVECTOR | bus.FLASH_SPACE | bus.ROM_SPACE |
                     bus.RTC_SPACE | bus.ATA_SPACE;

   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      rnw_d   = rnw_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (!bus.TSn && any_flag) begin
               rnw_d   = bus.RnW;
               state_d = S_SETUP;
               if (bus.AUTOVECTOR) begin
                  tgt_d   = T_AVEC;
                  state_d = S_TERM;
               end else if (bus.FLASH_SPACE) begin
                  tgt_d = T_FLASH;
                  cnt_d = FLASH_WS_E;
               end else if (bus.ROM_SPACE) begin
                  tgt_d = T_ROM;
                  cnt_d = ROM_WS_E;
               end else if (bus.RTC_SPACE) begin
                  tgt_d = T_RTC;
                  cnt_d = RTC_WS_E;
               end else begin
                  tgt_d = T_ATA;
                  cnt_d = ATA_WS_E;
               end
            end
         end
         S_SETUP:  state_d = S_STROBE;
         S_STROBE: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) state_d = S_TERM;
         end
         S_TERM:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they register in step with it.
      ce_on      = (state_d != S_IDLE) && (tgt_d != T_AVEC);
      strobe_on  = (state_d == S_STROBE);
      term_on    = (state_d == S_TERM);
      romcen_d   = !(ce_on && tgt_d == T_ROM);
      flashcen_d = !(ce_on && tgt_d == T_FLASH);
      rtccsn_d   = !(ce_on && tgt_d == T_RTC);
      atacsn_d   = !(ce_on && tgt_d == T_ATA);
      oen_d      = !(rnw_d && ce_on && (strobe_on || term_on));
      wen_d      = !(!rnw_d && strobe_on && tgt_d != T_ROM);
      tan_d      = !term_on;
      avecn_d    = !(term_on && tgt_d == T_AVEC);
      busy_d     = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK40) begin
      if (!RESETn) begin
         state_q    <= S_IDLE;
         tgt_q      <= T_ROM;
         rnw_q      <= 1'b1;
         cnt_q      <= 4'd0;
         tan_q      <= 1'b1;
         avecn_q    <= 1'b1;
         romcen_q   <= 1'b1;
         flashcen_q <= 1'b1;
         rtccsn_q   <= 1'b1;
         atacsn_q   <= 1'b1;
         oen_q      <= 1'b1;
         wen_q      <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tgt_q      <= tgt_d;
         rnw_q      <= rnw_d;
         cnt_q      <= cnt_d;
         tan_q      <= tan_d;
         avecn_q    <= avecn_d;
         romcen_q   <= romcen_d;
         flashcen_q <= flashcen_d;
         rtccsn_q   <= rtccsn_d;
         atacsn_q   <= atacsn_d;
         oen_q      <= oen_d;
         wen_q      <= wen_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.TAn      = tan_q;
   assign bus.AVECn    = avecn_q;
   assign bus.ROMCEn   = romcen_q;
   assign bus.FLASHCEn = flashcen_q;
   assign bus.RTCCSn   = rtccsn_q;
   assign bus.ATACSn   = atacsn_q;
   assign bus.OEn      = oen_q;
   assign bus.WEn      = wen_q;
   assign bus.BUSY     = busy_q;

endmodule

// File: tb/tb_u409_local_cycle_ctrl.sv
// Bench for u409_local_cycle_ctrl: directed test-plan cycles plus random cycles,
// each compared per clock against a timeline model of the cycle rules.
module tb_u409_local_cycle_ctrl;

   localparam int ROM_WS   = 4;
   localparam int FLASH_WS = 3;
   localparam int RTC_WS   = 8;
   localparam int ATA_WS   = 6;

   // {TAn, AVECn, ROMCEn, FLASHCEn, RTCCSn, ATACSn, OEn, WEn, BUSY}
   localparam logic [8:0] IDLE_V = 9'b1_1_1111_11_0;

   logic CLK40 = 1'b0;
   logic RESETn;
   int   checks   = 0;
   int   failures = 0;

   always #10 CLK40 = ~CLK40;

   u409_local_cycle_ctrl_if bus();

   u409_local_cycle_ctrl #(
      .ROM_WS(ROM_WS), .FLASH_WS(FLASH_WS), .RTC_WS(RTC_WS), .ATA_WS(ATA_WS)
   ) dut (
      .CLK40 (CLK40),
      .RESETn(RESETn),
      .bus   (bus)
   );

   function automatic logic [8:0] obs_vec();
      return {bus.TAn, bus.AVECn, bus.ROMCEn, bus.FLASHCEn, bus.RTCCSn,
              bus.ATACSn, bus.OEn, bus.WEn, bus.BUSY};
   endfunction

   // fl = {AUTOVECTOR, FLASH, ROM, RTC, ATA}
   function automatic int ws_for(input logic [4:0] fl);
      if (fl[4]) return 0;
      if (fl[3]) return FLASH_WS;
      if (fl[2]) return ROM_WS;
      if (fl[1]) return RTC_WS;
      return ATA_WS;
   endfunction

   function automatic int txn_len(input logic [4:0] fl);
      if (fl[4]) return 1;
      return ws_for(fl) + 2;
   endfunction

   // Expected outputs as sampled at edge N+k, where TSn was taken at edge N.
   function automatic logic [8:0] exp_vec(input logic [4:0] fl, input logic rnw, input int k);
      logic [8:0] v;
      int         ws;
      int         idx;
      bit         rom;
      v   = IDLE_V;
      rom = 1'b0;
      if (fl[4]) begin
         if (k == 1) begin
            v[8] = 1'b0;
            v[7] = 1'b0;
            v[0] = 1'b1;
         end
         return v;
      end
      if (fl[3])      idx = 5;
      else if (fl[2]) begin idx = 6; rom = 1'b1; end
      else if (fl[1]) idx = 4;
      else if (fl[0]) idx = 3;
      else return v;
      ws = ws_for(fl);
      if (k >= 1 && k <= ws + 2) begin
         v[idx] = 1'b0;
         v[0]   = 1'b1;
      end
      if (k >= 2 && k <= ws + 1) begin
         if (rnw)      v[2] = 1'b0;
         else if (!rom) v[1] = 1'b0;
      end
      if (k == ws + 2) begin
         v[8] = 1'b0;
         if (rnw) v[2] = 1'b0;
      end
      return v;
   endfunction

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
      end
   endtask

   task automatic drive(input logic tsn, input logic [4:0] fl, input logic rnw);
      bus.TSn = tsn;
      {bus.AUTOVECTOR, bus.FLASH_SPACE, bus.ROM_SPACE, bus.RTC_SPACE, bus.ATA_SPACE} = fl;
      bus.RnW = rnw;
   endtask

   // Starts at a falling edge; returns at the falling edge where the next TSn may be driven.
   task automatic run_txn(input string tag, input logic [4:0] fl, input logic rnw);
      int last;
      last = txn_len(fl) + 1;
      drive(1'b0, fl, rnw);
      for (int k = 1; k <= last; k++) begin
         @(negedge CLK40);
         chk($sformatf("%s k=%0d", tag, k), obs_vec(), exp_vec(fl, rnw, k));
         // TSn and flags are junk while the controller is busy and must be ignored.
         if (k < last) drive(1'($urandom_range(0, 1)), 5'($urandom), 1'($urandom_range(0, 1)));
         else          drive(1'b1, 5'd0, 1'b1);
      end
   endtask

   task automatic idle(input string tag, input int n, input logic unmapped);
      drive(!unmapped, 5'd0, 1'($urandom_range(0, 1)));
      for (int i = 0; i < n; i++) begin
         @(negedge CLK40);
         chk($sformatf("%s i=%0d", tag, i), obs_vec(), IDLE_V);
         drive(!unmapped, 5'd0, 1'($urandom_range(0, 1)));
      end
      drive(1'b1, 5'd0, 1'b1);
   endtask

   initial begin
      logic [4:0] fl;
      logic       rnw;

      RESETn = 1'b0;
      drive(1'b0, 5'b00100, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK40);
         chk($sformatf("reset i=%0d", i), obs_vec(), IDLE_V);
      end
      RESETn = 1'b1;
      idle("post_reset", 3, 1'b0);

      run_txn("rom_rd", 5'b00100, 1'b1);
      run_txn("flash_wr", 5'b01000, 1'b0);
      run_txn("avec_rom", 5'b10100, 1'b1);
      idle("unmapped", 20, 1'b1);
      run_txn("rtc_rd", 5'b00010, 1'b1);
      run_txn("ata_rd_b2b", 5'b00001, 1'b1);
      run_txn("rom_wr", 5'b00100, 1'b0);
      run_txn("prio_flash", 5'b01111, 1'b1);
      run_txn("prio_rom", 5'b00111, 1'b0);
      run_txn("prio_rtc", 5'b00011, 1'b0);
      run_txn("ata_wr", 5'b00001, 1'b0);
      run_txn("avec_all", 5'b11111, 1'b0);

      // Abort an RTC read in its strobe phase.
      drive(1'b0, 5'b00010, 1'b1);
      for (int k = 1; k <= 3; k++) begin
         @(negedge CLK40);
         chk($sformatf("abort_pre k=%0d", k), obs_vec(), exp_vec(5'b00010, 1'b1, k));
         drive(1'b1, 5'd0, 1'b1);
      end
      RESETn = 1'b0;
      @(negedge CLK40);
      chk("abort_reset", obs_vec(), IDLE_V);
      RESETn = 1'b1;
      idle("abort_quiet", 12, 1'b0);
      run_txn("after_abort", 5'b00010, 1'b0);

      for (int t = 0; t < 40; t++) begin
         fl  = 5'($urandom);
         if (fl == 5'd0) fl = 5'b00001;
         rnw = 1'($urandom_range(0, 1));
         run_txn($sformatf("rand%0d fl=%b rnw=%b", t, fl, rnw), fl, rnw);
         if ($urandom_range(0, 2) == 0)
            idle($sformatf("rand_gap%0d", t), $urandom_range(1, 3), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
